// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: sequencer states and counter width.
package pll_seq_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [2:0] {
      PLLRST,
      WAIT,
      STABLE,
      RUN,
      FAULT
   } pll_seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous level into the clock domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make both flops sample on the same edge, forming a real two-stage chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, qualifies lock, releases sys_rst and supervises lock on refclk.
// Define PLL_SEQ_RELOCK_EN to re-reset the PLL on lock loss in RUN instead of waiting for relock.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = 32,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 4,
   localparam int RETRY_W      = $clog2(MAX_RETRIES + 1)
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               restart,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   pll_seq_state_t     state, state_d;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_d;
   logic [RETRY_W-1:0] retry_inc;
   logic               locked_s;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   assign retry_inc = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 1'b1;

   // NOTE: every variable gets a default at the top so no path through the case can infer a latch.
   always_comb begin
      state_d = state;
      retry_d = retry_cnt;
      if (restart) begin
         state_d = PLLRST;
         retry_d = '0;
      end else begin
         case (state)
            PLLRST: if (cnt == CNT_W'(RST_CYCLES - 1)) state_d = WAIT;
            WAIT: begin
               if (locked_s) begin
                  state_d = STABLE;
               end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == RETRY_MAX) ? FAULT : PLLRST;
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state_d = WAIT;
               end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                  state_d = RUN;
                  retry_d = '0;
               end
            end
            RUN: begin
               // Relock policy: re-sequence the PLL, or wait for it to recover on its own.
               if (!locked_s) begin
`ifdef PLL_SEQ_RELOCK_EN
                  state_d = PLLRST;
`else
                  state_d = WAIT;
`endif
               end
            end
            FAULT:   state_d = FAULT;
            default: state_d = PLLRST;
         endcase
      end
   end

   // Outputs decode the next state so they change on the same edge as the state register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= PLLRST;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_d;
         retry_cnt <= retry_d;
         cnt       <= (restart || (state_d != state)) ? '0 : cnt + 1'b1;
         pll_rst   <= (state_d == PLLRST) || (state_d == FAULT);
         sys_rst   <= (state_d != RUN);
         ready     <= (state_d == RUN);
         fault     <= (state_d == FAULT);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus randomized lock/restart traffic.
module tb_pll_reset_sequencer;

   localparam int RST_C      = 4;
   localparam int TO_C       = 16;
   localparam int STB_C      = 8;
   localparam int MAX_R      = 2;
   localparam int RW         = $clog2(MAX_R + 1);
   localparam int READY_EDGE = RST_C + 1 + STB_C;
`ifdef PLL_SEQ_RELOCK_EN
   localparam bit RELOCK = 1'b1;
`else
   localparam bit RELOCK = 1'b0;
`endif

   typedef logic [RW+3:0] vec_t;  // {pll_rst, sys_rst, ready, fault, retry_cnt}
   localparam vec_t RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, {RW{1'b0}}};

   localparam int M_HOLD  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_STAB  = 2;
   localparam int M_RUN   = 3;
   localparam int M_FAULT = 4;

   logic          refclk     = 1'b0;
   logic          rst        = 1'b1;
   logic          pll_locked = 1'b0;
   logic          restart    = 1'b0;
   logic          pll_rst, sys_rst, ready, fault;
   logic [RW-1:0] retry_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase, edge of phase entry, retry count, and history of sampled lock.
   int m_phase, m_entry, m_edge, m_retry;
   bit lk_hist[$];

   always #10 refclk = ~refclk;

   pll_reset_sequencer #(
      .RST_CYCLES    (RST_C),
      .LOCK_TIMEOUT  (TO_C),
      .STABLE_CYCLES (STB_C),
      .MAX_RETRIES   (MAX_R)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .restart    (restart),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt)
   );

   function automatic vec_t obs_vec();
      return {pll_rst, sys_rst, ready, fault, retry_cnt};
   endfunction

   function automatic vec_t model_vec();
      return {(m_phase == M_HOLD) || (m_phase == M_FAULT), m_phase != M_RUN,
              m_phase == M_RUN, m_phase == M_FAULT, RW'(m_retry)};
   endfunction

   function automatic void enter(input int p);
      m_phase = p;
      m_entry = m_edge;
   endfunction

   // Advance one refclk edge; the model sees the inputs present at that edge.
   task automatic tick();
      bit ls;
      @(posedge refclk);
      #1;
      m_edge++;
      // Synchronized lock seen at edge n is the raw lock sampled at edge n-2.
      ls = (lk_hist.size() >= 2) ? lk_hist[lk_hist.size()-2] : 1'b0;
      if (restart) begin
         m_retry = 0;
         enter(M_HOLD);
      end else begin
         case (m_phase)
            M_HOLD: if (m_edge - m_entry == RST_C) enter(M_WAIT);
            M_WAIT: begin
               if (ls) enter(M_STAB);
               else if (m_edge - m_entry == TO_C) begin
                  m_retry++;
                  enter((m_retry == MAX_R) ? M_FAULT : M_HOLD);
               end
            end
            M_STAB: begin
               if (!ls) enter(M_WAIT);
               else if (m_edge - m_entry == STB_C) begin
                  m_retry = 0;
                  enter(M_RUN);
               end
            end
            M_RUN:   if (!ls) enter(RELOCK ? M_HOLD : M_WAIT);
            default: ;
         endcase
      end
      lk_hist.push_back(pll_locked);
   endtask

   task automatic do_reset(input logic lock);
      rst        = 1'b1;
      restart    = 1'b0;
      pll_locked = lock;
      repeat (2) @(posedge refclk);
      #1;
      m_phase = M_HOLD;
      m_entry = 0;
      m_edge  = 0;
      m_retry = 0;
      lk_hist.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge refclk);
      #1;
      n_checks++;
      if (obs_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_values: got %b want %b", obs_vec(), RST_VEC);
      end
   endtask

   task automatic test_powerup();
      vec_t exp;
      do_reset(1'b1);
      for (int e = 1; e <= READY_EDGE + 1; e++) begin
         tick();
         exp = {e < RST_C, e < READY_EDGE, e >= READY_EDGE, 1'b0, {RW{1'b0}}};
         n_checks++;
         if (obs_vec() !== exp) begin
            n_fail++;
            $display("FAIL powerup edge %0d: got %b want %b", e, obs_vec(), exp);
         end
      end
   endtask

   task automatic test_timeout_fault();
      vec_t exp;
      int   t1, t2;
      t1 = RST_C + TO_C;
      t2 = t1 + RST_C + TO_C;
      do_reset(1'b0);
      for (int e = 1; e <= t2 + 3; e++) begin
         tick();
         exp = {(e < RST_C) || (e >= t1 && e < t1 + RST_C) || (e >= t2), 1'b1, 1'b0, e >= t2,
                RW'((e >= t2) ? 2 : ((e >= t1) ? 1 : 0))};
         n_checks++;
         if (obs_vec() !== exp) begin
            n_fail++;
            $display("FAIL timeout_fault edge %0d: got %b want %b", e, obs_vec(), exp);
         end
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      n_checks++;
      if (obs_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL restart_from_fault: got %b want %b", obs_vec(), RST_VEC);
      end
      for (int k = 1; k <= RST_C; k++) begin
         tick();
         exp = {k < RST_C, 1'b1, 1'b0, 1'b0, {RW{1'b0}}};
         n_checks++;
         if (obs_vec() !== exp) begin
            n_fail++;
            $display("FAIL restart_hold %0d: got %b want %b", k, obs_vec(), exp);
         end
      end
   endtask

   task automatic test_stable_drop();
      vec_t exp;
      do_reset(1'b0);
      for (int e = 1; e <= 41; e++) begin
         tick();
         if (e >= 20) begin
            exp = {e < 24, e < 40, e >= 40, 1'b0, RW'((e < 40) ? 1 : 0)};
            n_checks++;
            if (obs_vec() !== exp) begin
               n_fail++;
               $display("FAIL stable_drop edge %0d: got %b want %b", e, obs_vec(), exp);
            end
         end
         if (e == 20) pll_locked = 1'b1;
         if (e == 26) pll_locked = 1'b0;
         if (e == 29) pll_locked = 1'b1;
      end
   endtask

   task automatic test_run_lockloss();
      vec_t exp;
      do_reset(1'b1);
      for (int e = 1; e <= 26; e++) begin
         tick();
         if (e >= 16) begin
            exp = {RELOCK && (e >= 18) && (e < 18 + RST_C), e >= 18, e < 18, 1'b0, {RW{1'b0}}};
            n_checks++;
            if (obs_vec() !== exp) begin
               n_fail++;
               $display("FAIL run_lockloss edge %0d: got %b want %b", e, obs_vec(), exp);
            end
         end
         if (e == 15) pll_locked = 1'b0;
      end
   endtask

   task automatic test_async_rst();
      do_reset(1'b1);
      repeat (READY_EDGE + 1) tick();
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_pre_run: ready got %b want 1", ready);
      end
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if (obs_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL async_rst_run: got %b want %b", obs_vec(), RST_VEC);
      end
      do_reset(1'b0);
      repeat (RST_C + 4) tick();
      n_checks++;
      if (pll_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL async_pre_wait: pll_rst got %b want 0", pll_rst);
      end
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if (obs_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL async_rst_wait: got %b want %b", obs_vec(), RST_VEC);
      end
   endtask

   task automatic test_restart_vs_run();
      vec_t exp;
      do_reset(1'b1);
      for (int e = 1; e <= 2 * READY_EDGE + 1; e++) begin
         if (e == READY_EDGE) restart = 1'b1;
         tick();
         restart = 1'b0;
         if (e >= READY_EDGE) begin
            exp = {e < READY_EDGE + RST_C, e < 2 * READY_EDGE, e >= 2 * READY_EDGE, 1'b0, {RW{1'b0}}};
            n_checks++;
            if (obs_vec() !== exp) begin
               n_fail++;
               $display("FAIL restart_vs_run edge %0d: got %b want %b", e, obs_vec(), exp);
            end
         end
      end
   endtask

   task automatic test_random();
      int seg;
      for (int ep = 0; ep < 6; ep++) begin
         do_reset(1'($urandom_range(0, 1)));
         seg = $urandom_range(1, 40);
         for (int c = 0; c < 500; c++) begin
            tick();
            n_checks++;
            if (obs_vec() !== model_vec()) begin
               n_fail++;
               $display("FAIL random ep %0d cyc %0d: got %b want %b", ep, c, obs_vec(), model_vec());
            end
            seg--;
            if (seg == 0) begin
               pll_locked = ~pll_locked;
               seg = $urandom_range(1, 40);
            end
            restart = ($urandom_range(0, 199) == 0);
         end
         restart = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_timeout_fault();
      test_stable_drop();
      test_run_lockloss();
      test_async_rst();
      test_restart_vs_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the core PLL (50 MHz in; 48/24/18/12 MHz out) and generates the design-wide reset. It holds the PLL in reset, waits for and qualifies lock, then releases the system reset. It supervises lock for the rest of operation, retries on timeout and latches a fault after repeated failures. It runs on the 50 MHz reference clock so it operates before and independently of any PLL output.

## Interface
Parameters:
- RST_CYCLES, 32: refclk cycles `pll_rst` is held high per attempt (≥2)
- LOCK_TIMEOUT, 65536: refclk cycles allowed in WAIT for lock before a retry (≥2)
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1)
- MAX_RETRIES, 4: lock timeouts tolerated before FAULT (≥1)

Ports:
- refclk  in  1  50 MHz reference clock; sole clock
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to refclk
- restart  in  1  synchronous one-cycle request to restart the sequence
- pll_rst  out  1  PLL reset, active high
- sys_rst  out  1  core reset, active high
- ready  out  1  high only in RUN
- fault  out  1  sticky; high only in FAULT
- retry_cnt  out  $clog2(MAX_RETRIES+1)  timeouts since the last RUN or restart

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- One cycle counter `cnt` (32-bit). It is cleared on every state change.
- All outputs are registered and change on the same edge as the state:
  - `pll_rst` = 1 in PLLRST and FAULT.
  - `sys_rst` = 0 only in RUN.
- States and transitions:
  - PLLRST: when `cnt == RST_CYCLES-1`, go to WAIT.
  - WAIT: if `locked_s` is high, go to STABLE. Otherwise, when `cnt == LOCK_TIMEOUT-1`, increment `retry_cnt`. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PLLRST.
  - STABLE: if `locked_s` is low, go to WAIT; `retry_cnt` is unchanged. When `cnt == STABLE_CYCLES-1` with `locked_s` high, go to RUN.
  - RUN: `retry_cnt` is cleared on entry. If `locked_s` is low, take the lock-loss path described under Configuration.
  - FAULT: stays here until `rst` or `restart`.
- `restart` is accepted in any state. It clears `retry_cnt` and `cnt` and enters PLLRST on the next edge. It has priority over all other transitions in that cycle.
- `retry_cnt` saturates at MAX_RETRIES.

## Timing
- Reset (`rst` high, asynchronous): state = PLLRST, `cnt` = 0, `retry_cnt` = 0, synchronizer flops = 0, `pll_rst` = 1, `sys_rst` = 1, `ready` = 0, `fault` = 0.
- `rst` asserted mid-sequence, including in RUN, aborts immediately to the reset values above.
- `pll_rst` stays high for exactly RST_CYCLES cycles after `rst` release.
- Lock latency: 2 cycles from `pll_locked` to `locked_s`.
- With lock already present: `ready` rises RST_CYCLES + 1 + STABLE_CYCLES edges after `rst` release.
- Lock loss in RUN: `sys_rst` rises 3 edges after `pll_locked` falls (2 synchronizer cycles + 1 state register).
- A `pll_locked` glitch shorter than one refclk period may be missed; this is acceptable.

## Configuration
- `PLL_SEQ_RELOCK_EN` defined: lock loss in RUN goes to PLLRST. The PLL is reset and re-sequenced, and the attempt counts as a fresh sequence with `retry_cnt` = 0.
- `PLL_SEQ_RELOCK_EN` undefined: lock loss in RUN goes to WAIT. `pll_rst` stays low, and the block waits for the PLL to relock on its own, with the normal timeout and retry rules.

## Structure
- Package `pll_seq_pkg`: state enum `pll_seq_state_t` (PLLRST, WAIT, STABLE, RUN, FAULT) and the counter width constant.
- One sub-module, `sync_2ff`: the 1-bit two-flop synchronizer, reset to 0.

## Test plan
Unless noted, the bench uses RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, `pll_locked` tied high → `pll_rst` high for 4 cycles; `ready` = 1 and `sys_rst` = 0 after the 13th edge; `retry_cnt` = 0.
- `pll_locked` held low → two PLLRST/WAIT cycles, `retry_cnt` goes 1 then 2, then FAULT: `fault` = 1, `pll_rst` = 1. A `restart` pulse → PLLRST with `retry_cnt` = 0 and `fault` = 0.
- Lock drops for 3 cycles while in STABLE → back to WAIT; `retry_cnt` unchanged; `ready` needs a full 8 stable cycles after lock returns.
- Lock loss in RUN, run once with and once without `PLL_SEQ_RELOCK_EN` → `sys_rst` rises 3 edges after the drop. With the macro, `pll_rst` pulses for 4 cycles; without it, `pll_rst` stays low.
- `rst` asserted asynchronously in RUN and in WAIT → all outputs return to their reset values immediately.
- `restart` in the same cycle as a STABLE→RUN transition → PLLRST wins; `ready` stays 0.
